pulse_interval_tx: RTL and testbench

- Upstream transmitter for the single-wire pulse-interval link into the coil-control receiver FSM.
- Generates the complete DATA_OUT pulse frame: sync, metadata and scan.
  - Sync: three edges, then a start edge.
  - Metadata: each bit is encoded as a pair of intervals (long/short comparison).
  - Scan: polarity-toggle pulses.
- Sits between the host/sequencer control logic and the DATA_IN pin of the receiver.

---
 rtl/pulse_interval_tx.sv | 207 ++++++++++++++++++++
 tb/tb_pulse_interval_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_interval_tx.sv
// Pulse-interval link transmitter: sync edges, interval-encoded metadata bits, then scan pulses.
// Optional even-parity trailer bit after the metadata is enabled by defining PULSE_TX_PARITY_EN.
module pulse_interval_tx #(
   parameter int SYNC_GAP    = 8,
   parameter int LONG_GAP    = 10,
   parameter int SHORT_GAP   = 4,
   parameter int SCAN_GAP    = 8,
   parameter int SCAN_PERIOD = 20,
   parameter int META_BITS   = 4,
   parameter int SCAN_CNT_W  = 8
) (
   input  logic                  CLK_IN,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [META_BITS-1:0]  meta,
   input  logic [SCAN_CNT_W-1:0] scan_count,
   output logic                  DATA_OUT,
   output logic                  busy,
   output logic                  done,
   output logic                  scan_pol,
   output logic [2:0]            phase
);

`ifdef PULSE_TX_PARITY_EN
   localparam int unsigned NB = META_BITS + 1;
`else
   localparam int unsigned NB = META_BITS;
`endif
   localparam int unsigned IW = $clog2(NB) + 1;

   // Counter reload values: a gap of G means G-1 idle edges between pulses
   localparam logic [15:0] SYNC_LD  = 16'(SYNC_GAP - 1);
   localparam logic [15:0] LONG_LD  = 16'(LONG_GAP - 1);
   localparam logic [15:0] SHORT_LD = 16'(SHORT_GAP - 1);
   localparam logic [15:0] SCAN_LD  = 16'(SCAN_GAP - 1);
   localparam logic [15:0] PER_LD   = 16'(SCAN_PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      META = 3'd2,
      SCAN = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [1:0]            sync_q, sync_d;
   logic [IW-1:0]         bit_q, bit_d, bit_nx;
   logic                  half_q, half_d;
   logic [NB-1:0]         meta_q, meta_d;
   logic [SCAN_CNT_W-1:0] scnt_q, scnt_d;
   logic [SCAN_CNT_W-1:0] left_q, left_d;
   logic                  fin_q, fin_d;
   logic                  dout_q, dout_d;
   logic                  pol_q, pol_d;
   logic                  b_cur, b_nxt;

   // Bit 1 = long then short, bit 0 = short then long
   function automatic logic [15:0] gap_ld(input logic b, input logic h);
      return (b ^ h) ? LONG_LD : SHORT_LD;
   endfunction

   always_ff @(posedge CLK_IN or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sync_q  <= '0;
         bit_q   <= '0;
         half_q  <= 1'b0;
         meta_q  <= '0;
         scnt_q  <= '0;
         left_q  <= '0;
         fin_q   <= 1'b0;
         dout_q  <= 1'b0;
         pol_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync_q  <= sync_d;
         bit_q   <= bit_d;
         half_q  <= half_d;
         meta_q  <= meta_d;
         scnt_q  <= scnt_d;
         left_q  <= left_d;
         fin_q   <= fin_d;
         dout_q  <= dout_d;
         pol_q   <= pol_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sync_d  = sync_q;
      bit_d   = bit_q;
      half_d  = half_q;
      meta_d  = meta_q;
      scnt_d  = scnt_q;
      left_d  = left_q;
      fin_d   = fin_q;
      dout_d  = 1'b0;
      pol_d   = pol_q;
      bit_nx  = bit_q + IW'(1);
      b_cur   = 1'b0;
      b_nxt   = 1'b0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (bit_q == IW'(i))  b_cur = meta_q[i];
         if (bit_nx == IW'(i)) b_nxt = meta_q[i];
      end

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = SYNC;
               dout_d  = 1'b1;
               cnt_d   = SYNC_LD;
               sync_d  = 2'd1;
`ifdef PULSE_TX_PARITY_EN
               meta_d  = {^meta, meta};
`else
               meta_d  = meta;
`endif
               scnt_d  = scan_count;
               pol_d   = 1'b0;
               fin_d   = 1'b0;
            end
         end
         SYNC: begin
            if (cnt_q == '0) begin
               dout_d = 1'b1;
               if (sync_q == 2'd3) begin
                  state_d = META;
                  bit_d   = '0;
                  half_d  = 1'b0;
                  cnt_d   = gap_ld(meta_q[0], 1'b0);
               end else begin
                  sync_d = sync_q + 2'd1;
                  cnt_d  = SYNC_LD;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         META: begin
            // fin_q marks that the final pulse went out last cycle
            if (fin_q) begin
               state_d = DONE;
               fin_d   = 1'b0;
            end else if (cnt_q == '0) begin
               dout_d = 1'b1;
               if (!half_q) begin
                  half_d = 1'b1;
                  cnt_d  = gap_ld(b_cur, 1'b1);
               end else begin
                  half_d = 1'b0;
                  if (bit_q == IW'(NB - 1)) begin
                     if (scnt_q != '0) begin
                        state_d = SCAN;
                        cnt_d   = SCAN_LD;
                        left_d  = scnt_q;
                     end else begin
                        fin_d = 1'b1;
                     end
                  end else begin
                     bit_d = bit_nx;
                     cnt_d = gap_ld(b_nxt, 1'b0);
                  end
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         SCAN: begin
            if (fin_q) begin
               state_d = DONE;
               fin_d   = 1'b0;
            end else if (cnt_q == '0) begin
               dout_d = 1'b1;
               pol_d  = (left_q == scnt_q) ? 1'b1 : ~pol_q;
               left_d = left_q - SCAN_CNT_W'(1);
               if (left_q == SCAN_CNT_W'(1)) fin_d = 1'b1;
               else                          cnt_d = PER_LD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         dout_d  = 1'b0;
         fin_d   = 1'b0;
         cnt_d   = '0;
      end
   end

   assign DATA_OUT = dout_q;
   assign scan_pol = pol_q;
   assign phase    = state_q;
   assign done     = (state_q == DONE);
   assign busy     = (state_q == SYNC) || (state_q == META) || (state_q == SCAN);

endmodule

// File: tb/tb_pulse_interval_tx.sv
// Directed bench for pulse_interval_tx with hand-derived pulse timings (default parameters).
module tb_pulse_interval_tx;

   logic       CLK_IN = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic       abort  = 1'b0;
   logic [3:0] meta   = '0;
   logic [7:0] scan_count = '0;
   logic       DATA_OUT, busy, done, scan_pol;
   logic [2:0] phase;

   int total = 0;
   int bad   = 0;

   logic       dout_a [0:399];
   logic       busy_a [0:399];
   logic       done_a [0:399];
   logic       pol_a  [0:399];
   logic [2:0] phase_a[0:399];
   int         pulses[$];

`ifdef PULSE_TX_PARITY_EN
   localparam int DONE_C = 144;
   localparam int S1     = 103;
   localparam int NP     = 17;
`else
   localparam int DONE_C = 130;
   localparam int S1     = 89;
   localparam int NP     = 15;
`endif

   pulse_interval_tx dut (
      .CLK_IN     (CLK_IN),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .meta       (meta),
      .scan_count (scan_count),
      .DATA_OUT   (DATA_OUT),
      .busy       (busy),
      .done       (done),
      .scan_pol   (scan_pol),
      .phase      (phase)
   );

   always #5 CLK_IN = ~CLK_IN;

   // Sample cycles 1..n (cycle k follows the k-th rising edge after launch)
   task automatic capture(input int n);
      pulses.delete();
      for (int k = 1; k <= n; k++) begin
         @(negedge CLK_IN);
         dout_a[k]  = DATA_OUT;
         busy_a[k]  = busy;
         done_a[k]  = done;
         pol_a[k]   = scan_pol;
         phase_a[k] = phase;
         if (DATA_OUT) pulses.push_back(k);
      end
   endtask

   task automatic launch(input logic [3:0] m, input logic [7:0] s);
      meta = m;
      scan_count = s;
      start = 1'b1;
      @(posedge CLK_IN);
      #1 start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge CLK_IN);
      @(negedge CLK_IN);
      total++; if (DATA_OUT !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b exp=0", DATA_OUT); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (scan_pol !== 1'b0) begin bad++; $display("FAIL reset_pol got=%b exp=0", scan_pol); end
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
      rst_n = 1'b1;
      capture(4);
      total++; if (pulses.size() !== 0) begin bad++; $display("FAIL idle_quiet got=%0d exp=0", pulses.size()); end
   endtask

   task automatic test_frame_basic();
      int exp_p[$];
      int dbl, ndone;
`ifdef PULSE_TX_PARITY_EN
      exp_p = '{1, 9, 17, 25, 35, 39, 43, 53, 57, 67, 71, 81, 91, 95, 103, 123, 143};
`else
      exp_p = '{1, 9, 17, 25, 35, 39, 43, 53, 57, 67, 71, 81, 89, 109, 129};
`endif
      launch(4'b0001, 8'd3);
      capture(160);
      total++; if (pulses.size() !== exp_p.size()) begin bad++; $display("FAIL basic_npulse got=%0d exp=%0d", pulses.size(), exp_p.size()); end
      for (int i = 0; i < exp_p.size() && i < pulses.size(); i++) begin
         total++; if (pulses[i] !== exp_p[i]) begin bad++; $display("FAIL basic_pulse%0d got=%0d exp=%0d", i, pulses[i], exp_p[i]); end
      end
      dbl = 0; ndone = 0;
      for (int k = 1; k < 160; k++) begin
         if (dout_a[k] && dout_a[k+1]) dbl++;
         if (done_a[k]) ndone++;
      end
      total++; if (dbl !== 0) begin bad++; $display("FAIL basic_double_high got=%0d exp=0", dbl); end
      total++; if (ndone !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", ndone); end
      total++; if (done_a[DONE_C] !== 1'b1) begin bad++; $display("FAIL basic_done_cycle got=%b exp=1", done_a[DONE_C]); end
      total++; if (busy_a[1] !== 1'b1) begin bad++; $display("FAIL basic_busy_first got=%b exp=1", busy_a[1]); end
      total++; if (busy_a[DONE_C-1] !== 1'b1) begin bad++; $display("FAIL basic_busy_last got=%b exp=1", busy_a[DONE_C-1]); end
      total++; if (busy_a[DONE_C] !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b exp=0", busy_a[DONE_C]); end
      total++; if (pol_a[S1-1] !== 1'b0) begin bad++; $display("FAIL basic_pol_pre got=%b exp=0", pol_a[S1-1]); end
      total++; if (pol_a[S1] !== 1'b1) begin bad++; $display("FAIL basic_pol1 got=%b exp=1", pol_a[S1]); end
      total++; if (pol_a[S1+20] !== 1'b0) begin bad++; $display("FAIL basic_pol2 got=%b exp=0", pol_a[S1+20]); end
      total++; if (pol_a[S1+40] !== 1'b1) begin bad++; $display("FAIL basic_pol3 got=%b exp=1", pol_a[S1+40]); end
      total++; if (phase_a[5] !== 3'd1) begin bad++; $display("FAIL basic_phase_sync got=%0d exp=1", phase_a[5]); end
      total++; if (phase_a[30] !== 3'd2) begin bad++; $display("FAIL basic_phase_meta got=%0d exp=2", phase_a[30]); end
      total++; if (phase_a[S1] !== 3'd3) begin bad++; $display("FAIL basic_phase_scan got=%0d exp=3", phase_a[S1]); end
      total++; if (phase_a[DONE_C] !== 3'd4) begin bad++; $display("FAIL basic_phase_done got=%0d exp=4", phase_a[DONE_C]); end
      total++; if (phase_a[DONE_C+1] !== 3'd0) begin bad++; $display("FAIL basic_phase_idle got=%0d exp=0", phase_a[DONE_C+1]); end
   endtask

   task automatic test_no_scan();
      int exp_p[$];
      int nd, npol;
`ifdef PULSE_TX_PARITY_EN
      exp_p = '{1, 9, 17, 25, 29, 39, 49, 53, 57, 67, 77, 81, 85, 95};
      nd = 96;
`else
      exp_p = '{1, 9, 17, 25, 29, 39, 49, 53, 57, 67, 77, 81};
      nd = 82;
`endif
      launch(4'b1010, 8'd0);
      capture(110);
      total++; if (pulses.size() !== exp_p.size()) begin bad++; $display("FAIL noscan_npulse got=%0d exp=%0d", pulses.size(), exp_p.size()); end
      for (int i = 0; i < exp_p.size() && i < pulses.size(); i++) begin
         total++; if (pulses[i] !== exp_p[i]) begin bad++; $display("FAIL noscan_pulse%0d got=%0d exp=%0d", i, pulses[i], exp_p[i]); end
      end
      total++; if (done_a[nd] !== 1'b1) begin bad++; $display("FAIL noscan_done got=%b exp=1", done_a[nd]); end
      total++; if (done_a[nd-1] !== 1'b0) begin bad++; $display("FAIL noscan_done_early got=%b exp=0", done_a[nd-1]); end
      total++; if (busy_a[nd] !== 1'b0) begin bad++; $display("FAIL noscan_busy got=%b exp=0", busy_a[nd]); end
      npol = 0;
      for (int k = 1; k <= 110; k++) if (pol_a[k]) npol++;
      total++; if (npol !== 0) begin bad++; $display("FAIL noscan_pol got=%0d exp=0", npol); end
   endtask

   task automatic test_meta_0111();
      int exp_p[$];
      int nd;
`ifdef PULSE_TX_PARITY_EN
      exp_p = '{1, 9, 17, 25, 35, 39, 49, 53, 63, 67, 71, 81, 91, 95, 103};
      nd = 104;
`else
      exp_p = '{1, 9, 17, 25, 35, 39, 49, 53, 63, 67, 71, 81, 89};
      nd = 90;
`endif
      launch(4'b0111, 8'd1);
      capture(120);
      total++; if (pulses.size() !== exp_p.size()) begin bad++; $display("FAIL m0111_npulse got=%0d exp=%0d", pulses.size(), exp_p.size()); end
      for (int i = 0; i < exp_p.size() && i < pulses.size(); i++) begin
         total++; if (pulses[i] !== exp_p[i]) begin bad++; $display("FAIL m0111_pulse%0d got=%0d exp=%0d", i, pulses[i], exp_p[i]); end
      end
      total++; if (done_a[nd] !== 1'b1) begin bad++; $display("FAIL m0111_done got=%b exp=1", done_a[nd]); end
      total++; if (pol_a[nd-1] !== 1'b1) begin bad++; $display("FAIL m0111_pol got=%b exp=1", pol_a[nd-1]); end
   endtask

   task automatic test_abort();
      int nev;
      launch(4'b0001, 8'd3);
      capture(40);
      total++; if (phase_a[40] !== 3'd2) begin bad++; $display("FAIL abort_pre_phase got=%0d exp=2", phase_a[40]); end
      abort = 1'b1;
      @(negedge CLK_IN);
      abort = 1'b0;
      total++; if (DATA_OUT !== 1'b0) begin bad++; $display("FAIL abort_dout got=%b exp=0", DATA_OUT); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL abort_phase got=%0d exp=0", phase); end
      capture(9);
      nev = 0;
      for (int k = 1; k <= 9; k++) if (done_a[k] || dout_a[k] || busy_a[k]) nev++;
      total++; if (nev !== 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", nev); end
      start = 1'b1;
      @(negedge CLK_IN);
      start = 1'b0;
      total++; if (DATA_OUT !== 1'b1) begin bad++; $display("FAIL abort_restart_dout got=%b exp=1", DATA_OUT); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_restart_busy got=%b exp=1", busy); end
      abort = 1'b1;
      @(negedge CLK_IN);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_sync_busy got=%b exp=0", busy); end
      start = 1'b1;
      @(negedge CLK_IN);
      start = 1'b0;
      abort = 1'b0;
      total++; if (DATA_OUT !== 1'b0) begin bad++; $display("FAIL abort_prio_dout got=%b exp=0", DATA_OUT); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_prio_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      int nev;
      launch(4'b0001, 8'd3);
      capture(95);
      total++; if (pol_a[95] !== 1'b1) begin bad++; $display("FAIL rstmid_pre_pol got=%b exp=1", pol_a[95]); end
      rst_n = 1'b0;
      #1;
      total++; if (DATA_OUT !== 1'b0) begin bad++; $display("FAIL rstmid_dout got=%b exp=0", DATA_OUT); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      total++; if (scan_pol !== 1'b0) begin bad++; $display("FAIL rstmid_pol got=%b exp=0", scan_pol); end
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL rstmid_phase got=%0d exp=0", phase); end
      @(negedge CLK_IN);
      rst_n = 1'b1;
      capture(40);
      nev = 0;
      for (int k = 1; k <= 40; k++) if (done_a[k] || dout_a[k]) nev++;
      total++; if (nev !== 0) begin bad++; $display("FAIL rstmid_quiet got=%0d exp=0", nev); end
      launch(4'b0001, 8'd3);
      capture(160);
      total++; if (pulses.size() !== NP) begin bad++; $display("FAIL rstmid_npulse got=%0d exp=%0d", pulses.size(), NP); end
      total++; if (done_a[DONE_C] !== 1'b1) begin bad++; $display("FAIL rstmid_done got=%b exp=1", done_a[DONE_C]); end
      if (pulses.size() == NP) begin
         total++; if (pulses[NP-1] !== S1 + 40) begin bad++; $display("FAIL rstmid_last got=%0d exp=%0d", pulses[NP-1], S1 + 40); end
      end
   endtask

   task automatic test_back_to_back();
      int n1, n2;
      meta = 4'b0001;
      scan_count = 8'd3;
      start = 1'b1;
      @(posedge CLK_IN);
      #1;
      capture(2 * DONE_C + 3);
      start = 1'b0;
      n1 = 0; n2 = 0;
      foreach (pulses[i]) begin
         if (pulses[i] <= DONE_C) n1++;
         else if (pulses[i] <= 2 * DONE_C + 1) n2++;
      end
      total++; if (n1 !== NP) begin bad++; $display("FAIL b2b_frame1_n got=%0d exp=%0d", n1, NP); end
      total++; if (n2 !== NP) begin bad++; $display("FAIL b2b_frame2_n got=%0d exp=%0d", n2, NP); end
      total++; if (done_a[DONE_C] !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", done_a[DONE_C]); end
      total++; if (busy_a[DONE_C+1] !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy_a[DONE_C+1]); end
      total++; if (dout_a[DONE_C+2] !== 1'b1) begin bad++; $display("FAIL b2b_frame2_start got=%b exp=1", dout_a[DONE_C+2]); end
      total++; if (done_a[2*DONE_C+1] !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done_a[2*DONE_C+1]); end
      total++; if (dout_a[2*DONE_C+3] !== 1'b1) begin bad++; $display("FAIL b2b_frame3_start got=%b exp=1", dout_a[2*DONE_C+3]); end
      abort = 1'b1;
      @(negedge CLK_IN);
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame_basic();
      test_no_scan();
      test_meta_0111();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
